// File: rtl/data_path_param_if.sv
// Control/memory-facing bundle for data_path_param. The master side is the
// control unit plus memory block; the slave side is the data path itself.
interface data_path_param_if #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int NUM_REGS = 4
);
  localparam int RSEL_W = $clog2(NUM_REGS);

  logic [DATA_W-1:0] from_memory;
  logic [2:0]        ALU_Sel;
  logic [1:0]        Bus1_Sel;
  logic [1:0]        Bus2_Sel;
  logic [RSEL_W-1:0] Rs_Sel;
  logic [RSEL_W-1:0] Rt_Sel;
  logic [RSEL_W-1:0] Rd_Sel;
  logic              Rd_Load;
  logic              IR_Load;
  logic              MAR_Load;
  logic              PC_Load;
  logic              PC_Inc;
  logic              CCR_Load;
  logic              MAR_Src;
  logic              SP_Inc;
  logic              SP_Dec;
  logic              SP_Fault_Clr;
  logic [3:0]        CCR_Mask;

  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] to_memory;
  logic [DATA_W-1:0] IR_out;
  logic [3:0]        CCR_Result;
  logic              sp_fault;

  modport master (
    output from_memory, ALU_Sel, Bus1_Sel, Bus2_Sel, Rs_Sel, Rt_Sel, Rd_Sel,
           Rd_Load, IR_Load, MAR_Load, PC_Load, PC_Inc, CCR_Load, MAR_Src,
           SP_Inc, SP_Dec, SP_Fault_Clr, CCR_Mask,
    input  address, to_memory, IR_out, CCR_Result, sp_fault
  );

  modport slave (
    input  from_memory, ALU_Sel, Bus1_Sel, Bus2_Sel, Rs_Sel, Rt_Sel, Rd_Sel,
           Rd_Load, IR_Load, MAR_Load, PC_Load, PC_Inc, CCR_Load, MAR_Src,
           SP_Inc, SP_Dec, SP_Fault_Clr, CCR_Mask,
    output address, to_memory, IR_out, CCR_Result, sp_fault
  );
endinterface

// File: rtl/data_path_param.sv
// Parametrised two-bus CPU data path: register file, PC, SP with sticky
// over/underflow flag, MAR, IR, ALU and masked NZVC condition codes.
module data_path_param #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 8,
  parameter int                NUM_REGS = 4,
  parameter logic [ADDR_W-1:0] PC_RESET = '0,
  parameter logic [ADDR_W-1:0] SP_RESET = '1
) (
  input logic              clk,
  input logic              reset,
  data_path_param_if.slave bus
);
  localparam int MSB = DATA_W - 1;

  logic [ADDR_W-1:0] pc, sp, mar;
  logic [DATA_W-1:0] ir;
  logic [3:0]        ccr;
  logic              sp_fault_q;
  logic [DATA_W-1:0] regs [NUM_REGS];

  logic [DATA_W-1:0] bus1, bus2, alu_a, alu_r;
  logic [DATA_W:0]   alu_ext;
  logic              alu_c, alu_v;
  logic [3:0]        nzvc;
  logic              sp_inc_only, sp_dec_only, sp_fault_set;

  assign alu_a = regs[bus.Rt_Sel];

  // Bus1 source mux; address-width registers are resized onto the data bus
  always_comb begin
    bus1 = '0;
    case (bus.Bus1_Sel)
      2'b00:   bus1 = DATA_W'(pc);
      2'b01:   bus1 = regs[bus.Rs_Sel];
      2'b10:   bus1 = DATA_W'(sp);
      default: bus1 = '0;
    endcase
  end

  // ALU: A from the register file, B from Bus1; one extra bit carries C/borrow
  always_comb begin
    alu_ext = '0;
    alu_r   = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (bus.ALU_Sel)
      3'b000: begin
        alu_ext = {1'b0, alu_a} + {1'b0, bus1};
        alu_r   = alu_ext[MSB:0];
        alu_c   = alu_ext[DATA_W];
        alu_v   = (alu_a[MSB] == bus1[MSB]) && (alu_r[MSB] != alu_a[MSB]);
      end
      3'b001: begin
        alu_ext = {1'b0, alu_a} - {1'b0, bus1};
        alu_r   = alu_ext[MSB:0];
        alu_c   = alu_ext[DATA_W];
        alu_v   = (alu_a[MSB] != bus1[MSB]) && (alu_r[MSB] != alu_a[MSB]);
      end
      3'b010: alu_r = alu_a & bus1;
      3'b011: alu_r = alu_a | bus1;
      3'b100: alu_r = alu_a ^ bus1;
      3'b101: begin
        alu_ext = {1'b0, bus1} + (DATA_W+1)'(1);
        alu_r   = alu_ext[MSB:0];
        alu_c   = alu_ext[DATA_W];
        alu_v   = !bus1[MSB] && alu_r[MSB];
      end
      3'b110: begin
        alu_ext = {1'b0, bus1} - (DATA_W+1)'(1);
        alu_r   = alu_ext[MSB:0];
        alu_c   = alu_ext[DATA_W];
        alu_v   = bus1[MSB] && !alu_r[MSB];
      end
      default: alu_r = ~bus1;
    endcase
    nzvc = {alu_r[MSB], (alu_r == '0), alu_v, alu_c};
  end

  // Bus2 writeback mux
  always_comb begin
    bus2 = '0;
    case (bus.Bus2_Sel)
      2'b00:   bus2 = alu_r;
      2'b01:   bus2 = bus1;
      2'b10:   bus2 = bus.from_memory;
      default: bus2 = '0;
    endcase
  end

  assign sp_inc_only  = bus.SP_Inc && !bus.SP_Dec;
  assign sp_dec_only  = bus.SP_Dec && !bus.SP_Inc;
  assign sp_fault_set = (sp_dec_only && (sp == '0)) || (sp_inc_only && (sp == '1));

  // Register file write port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (bus.Rd_Load) begin
      regs[bus.Rd_Sel] <= bus2;
    end
  end

  // PC: load beats increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            pc <= PC_RESET;
    else if (bus.PC_Load) pc <= ADDR_W'(bus2);
    else if (bus.PC_Inc)  pc <= pc + 1'b1;
  end

  // SP and its sticky fault flag; a new fault wins over a same-cycle clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp         <= SP_RESET;
      sp_fault_q <= 1'b0;
    end else begin
      if (sp_inc_only)      sp <= sp + 1'b1;
      else if (sp_dec_only) sp <= sp - 1'b1;
      if (sp_fault_set)          sp_fault_q <= 1'b1;
      else if (bus.SP_Fault_Clr) sp_fault_q <= 1'b0;
    end
  end

  // MAR takes the pre-edge SP so a push can load MAR and decrement together
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             mar <= '0;
    else if (bus.MAR_Load) mar <= bus.MAR_Src ? sp : ADDR_W'(bus2);
  end

  // IR and per-bit masked CCR update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir  <= '0;
      ccr <= '0;
    end else begin
      if (bus.IR_Load)  ir  <= bus2;
      if (bus.CCR_Load) ccr <= (ccr & ~bus.CCR_Mask) | (nzvc & bus.CCR_Mask);
    end
  end

  assign bus.address    = mar;
  assign bus.to_memory  = bus1;
  assign bus.IR_out     = ir;
  assign bus.CCR_Result = ccr;
  assign bus.sp_fault   = sp_fault_q;
endmodule

// File: tb/tb_data_path_param.sv
// Bench for data_path_param: default 8/8/4 instance driven by directed and
// random stimulus against an arithmetic reference model, plus a 16/12/8
// instance for width conversion and register-file independence.
module tb_data_path_param;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  data_path_param_if #(.DATA_W(8),  .ADDR_W(8),  .NUM_REGS(4)) d1 ();
  data_path_param_if #(.DATA_W(16), .ADDR_W(12), .NUM_REGS(8)) d2 ();

  data_path_param #(.DATA_W(8), .ADDR_W(8), .NUM_REGS(4),
                    .PC_RESET(8'h00), .SP_RESET(8'hFF))
    dut (.clk(clk), .reset(reset), .bus(d1));

  data_path_param #(.DATA_W(16), .ADDR_W(12), .NUM_REGS(8))
    dut2 (.clk(clk), .reset(reset), .bus(d2));

  typedef struct packed {
    logic [7:0] address;
    logic [7:0] to_mem;
    logic [7:0] ir;
    logic [3:0] ccr;
    logic       fault;
  } exp1_t;

  typedef struct packed {
    logic [15:0] to_mem;
    logic [11:0] address;
  } exp2_t;

  exp1_t exp_q[$];
  exp2_t exp2_q[$];
  int errors = 0;
  int checks = 0;

  // reference model state for the 8-bit instance
  logic [7:0] m_reg [4];
  logic [7:0] m_pc, m_sp, m_mar, m_ir;
  logic [3:0] m_ccr;
  logic       m_fault;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sval(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  function automatic logic [7:0] m_bus1();
    case (d1.Bus1_Sel)
      2'd0:    return m_pc;
      2'd1:    return m_reg[d1.Rs_Sel];
      2'd2:    return m_sp;
      default: return 8'h00;
    endcase
  endfunction

  task automatic alu_model(output logic [7:0] r, output logic [3:0] f);
    int a, b, t, s;
    bit c, v;
    a = int'(m_reg[d1.Rt_Sel]);
    b = int'(m_bus1());
    c = 0; v = 0; t = 0;
    case (d1.ALU_Sel)
      3'd0: begin t = a + b; c = (t > 255); s = sval(a) + sval(b); v = (s > 127) || (s < -128); end
      3'd1: begin t = a - b; c = (a < b);   s = sval(a) - sval(b); v = (s > 127) || (s < -128); end
      3'd2: t = a & b;
      3'd3: t = a | b;
      3'd4: t = a ^ b;
      3'd5: begin t = b + 1; c = (b == 255); v = (sval(b) + 1 > 127); end
      3'd6: begin t = b - 1; c = (b == 0);   v = (sval(b) - 1 < -128); end
      default: t = 255 - b;
    endcase
    r = 8'(t & 255);
    f = {r >= 8'd128, r == 8'd0, v, c};
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
    m_pc = 8'h00; m_sp = 8'hFF; m_mar = 8'h00; m_ir = 8'h00;
    m_ccr = 4'h0; m_fault = 1'b0;
  endtask

  task automatic model_edge();
    logic [7:0] b1, r, b2, old_sp;
    logic [3:0] f;
    bit setf;
    b1 = m_bus1();
    alu_model(r, f);
    case (d1.Bus2_Sel)
      2'd0:    b2 = r;
      2'd1:    b2 = b1;
      2'd2:    b2 = d1.from_memory;
      default: b2 = 8'h00;
    endcase
    old_sp = m_sp;
    setf = 0;
    if (d1.Rd_Load)  m_reg[d1.Rd_Sel] = b2;
    if (d1.IR_Load)  m_ir = b2;
    if (d1.MAR_Load) m_mar = d1.MAR_Src ? old_sp : b2;
    if (d1.PC_Load)     m_pc = b2;
    else if (d1.PC_Inc) m_pc = 8'((int'(m_pc) + 1) % 256);
    if (d1.SP_Inc && !d1.SP_Dec) begin
      setf = (old_sp == 8'd255);
      m_sp = 8'((int'(old_sp) + 1) % 256);
    end else if (d1.SP_Dec && !d1.SP_Inc) begin
      setf = (old_sp == 8'd0);
      m_sp = 8'((int'(old_sp) + 255) % 256);
    end
    if (setf)                 m_fault = 1'b1;
    else if (d1.SP_Fault_Clr) m_fault = 1'b0;
    if (d1.CCR_Load)
      for (int i = 0; i < 4; i++)
        if (d1.CCR_Mask[i]) m_ccr[i] = f[i];
  endtask

  task automatic push_exp();
    exp_q.push_back('{m_mar, m_bus1(), m_ir, m_ccr, m_fault});
  endtask

  // inputs already applied just after a rising edge; expect, clock, update model
  task automatic step();
    push_exp();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic step2(input logic [15:0] tm, input logic [11:0] addr);
    exp2_q.push_back('{tm, addr});
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    d1.from_memory = 8'h00; d1.ALU_Sel = 3'd0; d1.Bus1_Sel = 2'd0; d1.Bus2_Sel = 2'd0;
    d1.Rs_Sel = 2'd0; d1.Rt_Sel = 2'd0; d1.Rd_Sel = 2'd0;
    d1.Rd_Load = 0; d1.IR_Load = 0; d1.MAR_Load = 0; d1.PC_Load = 0; d1.PC_Inc = 0;
    d1.CCR_Load = 0; d1.MAR_Src = 0; d1.SP_Inc = 0; d1.SP_Dec = 0; d1.SP_Fault_Clr = 0;
    d1.CCR_Mask = 4'h0;
  endtask

  task automatic idle2();
    d2.from_memory = 16'h0000; d2.ALU_Sel = 3'd0; d2.Bus1_Sel = 2'd0; d2.Bus2_Sel = 2'd0;
    d2.Rs_Sel = 3'd0; d2.Rt_Sel = 3'd0; d2.Rd_Sel = 3'd0;
    d2.Rd_Load = 0; d2.IR_Load = 0; d2.MAR_Load = 0; d2.PC_Load = 0; d2.PC_Inc = 0;
    d2.CCR_Load = 0; d2.MAR_Src = 0; d2.SP_Inc = 0; d2.SP_Dec = 0; d2.SP_Fault_Clr = 0;
    d2.CCR_Mask = 4'h0;
  endtask

  task automatic rand_inputs();
    d1.from_memory = 8'($urandom);
    d1.ALU_Sel  = 3'($urandom_range(0, 7));
    d1.Bus1_Sel = 2'($urandom_range(0, 3));
    d1.Bus2_Sel = 2'($urandom_range(0, 3));
    d1.Rs_Sel = 2'($urandom_range(0, 3));
    d1.Rt_Sel = 2'($urandom_range(0, 3));
    d1.Rd_Sel = 2'($urandom_range(0, 3));
    d1.Rd_Load  = ($urandom_range(0, 1) == 0);
    d1.IR_Load  = ($urandom_range(0, 3) == 0);
    d1.MAR_Load = ($urandom_range(0, 2) == 0);
    d1.PC_Load  = ($urandom_range(0, 3) == 0);
    d1.PC_Inc   = ($urandom_range(0, 1) == 0);
    d1.CCR_Load = ($urandom_range(0, 1) == 0);
    d1.MAR_Src  = ($urandom_range(0, 1) == 0);
    d1.SP_Inc   = ($urandom_range(0, 2) == 0);
    d1.SP_Dec   = ($urandom_range(0, 2) == 0);
    d1.SP_Fault_Clr = ($urandom_range(0, 7) == 0);
    d1.CCR_Mask = 4'($urandom_range(0, 15));
  endtask

  // reset asserted between edges with strobes pending; checked before any edge
  task automatic async_reset();
    rand_inputs();
    d1.Bus1_Sel = 2'd2;
    #1;
    reset = 1'b1;
    model_reset();
    push_exp();
    @(posedge clk);
    #1;
    push_exp();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // monitor: every falling edge compares outputs against queued expectations
  always @(negedge clk) begin
    exp1_t e;
    exp2_t e2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cmp("address",    32'(d1.address),    32'(e.address));
      cmp("to_memory",  32'(d1.to_memory),  32'(e.to_mem));
      cmp("IR_out",     32'(d1.IR_out),     32'(e.ir));
      cmp("CCR_Result", 32'(d1.CCR_Result), 32'(e.ccr));
      cmp("sp_fault",   32'(d1.sp_fault),   32'(e.fault));
    end
    if (exp2_q.size() > 0) begin
      e2 = exp2_q.pop_front();
      cmp("w16_to_memory", 32'(d2.to_memory), 32'(e2.to_mem));
      cmp("w16_address",   32'(d2.address),   32'(e2.address));
    end
  end

  logic [15:0] vals [8];

  initial begin
    idle();
    idle2();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // reg1=7F, reg2=01
    idle(); d1.Bus2_Sel = 2'd2; d1.Rd_Load = 1; d1.Rd_Sel = 2'd1; d1.from_memory = 8'h7F; step();
    idle(); d1.Bus2_Sel = 2'd2; d1.Rd_Load = 1; d1.Rd_Sel = 2'd2; d1.from_memory = 8'h01; step();
    // 7F+01 -> reg3, flags 1010
    idle(); d1.Rt_Sel = 2'd1; d1.Bus1_Sel = 2'd1; d1.Rs_Sel = 2'd2; d1.ALU_Sel = 3'd0;
    d1.CCR_Load = 1; d1.CCR_Mask = 4'hF; d1.Rd_Load = 1; d1.Rd_Sel = 2'd3; step();
    // 00-01 -> reg0, flags 1001
    idle(); d1.Rt_Sel = 2'd0; d1.Bus1_Sel = 2'd1; d1.Rs_Sel = 2'd2; d1.ALU_Sel = 3'd1;
    d1.CCR_Load = 1; d1.CCR_Mask = 4'hF; d1.Rd_Load = 1; d1.Rd_Sel = 2'd0; step();
    idle(); d1.Bus1_Sel = 2'd1; d1.Rs_Sel = 2'd3; step();
    idle(); d1.Bus1_Sel = 2'd1; d1.Rs_Sel = 2'd0; step();
    // 80+80 (flags 0111) masked 0111 -> CCR 1111
    idle(); d1.Rt_Sel = 2'd3; d1.Bus1_Sel = 2'd1; d1.Rs_Sel = 2'd3; d1.ALU_Sel = 3'd0;
    d1.CCR_Load = 1; d1.CCR_Mask = 4'b0111; step();
    // 7F & 80 = 0: mask 0100 holds 1111, mask 1000 gives 0111
    idle(); d1.Rt_Sel = 2'd1; d1.Bus1_Sel = 2'd1; d1.Rs_Sel = 2'd3; d1.ALU_Sel = 3'd2;
    d1.CCR_Load = 1; d1.CCR_Mask = 4'b0100; step();
    d1.CCR_Mask = 4'b1000; step();
    idle(); step();

    // stack: FF -> 00 (overflow) -> 01, clear, push, underflow, set-beats-clear
    idle(); d1.Bus1_Sel = 2'd2; d1.SP_Inc = 1; step();
    step();
    idle(); d1.Bus1_Sel = 2'd2; d1.SP_Fault_Clr = 1; step();
    idle(); d1.Bus1_Sel = 2'd2; d1.MAR_Src = 1; d1.MAR_Load = 1; d1.SP_Dec = 1; step();
    idle(); d1.Bus1_Sel = 2'd2; d1.SP_Dec = 1; step();
    idle(); d1.Bus1_Sel = 2'd2; d1.SP_Inc = 1; d1.SP_Dec = 1; step();
    idle(); d1.Bus1_Sel = 2'd2; d1.SP_Inc = 1; step();
    idle(); d1.Bus1_Sel = 2'd2; d1.SP_Fault_Clr = 1; step();
    idle(); d1.Bus1_Sel = 2'd2; d1.SP_Fault_Clr = 1; d1.SP_Dec = 1; step();
    idle(); d1.Bus1_Sel = 2'd2; step();

    // PC wrap and load-over-increment
    idle(); d1.Bus2_Sel = 2'd2; d1.from_memory = 8'hFF; d1.PC_Load = 1; step();
    idle(); d1.PC_Inc = 1; step();
    idle(); d1.Bus2_Sel = 2'd2; d1.from_memory = 8'h40; d1.PC_Load = 1; d1.PC_Inc = 1; step();
    idle(); step();

    // IR and MAR from Bus2
    idle(); d1.Bus2_Sel = 2'd2; d1.from_memory = 8'hA5; d1.IR_Load = 1; d1.MAR_Load = 1; step();
    idle(); step();

    repeat (500) begin
      rand_inputs();
      step();
    end

    async_reset();
    idle(); d1.Bus1_Sel = 2'd2; step();
    idle(); step();

    // wide instance: reset SP, truncating PC/MAR loads, independent registers
    idle2(); d2.Bus1_Sel = 2'd2; step2(16'h0FFF, 12'h000);
    idle2(); d2.Bus2_Sel = 2'd2; d2.from_memory = 16'hABCD; d2.PC_Load = 1; d2.MAR_Load = 1;
    step2(16'h0000, 12'h000);
    idle2(); step2(16'h0BCD, 12'hBCD);
    for (int i = 0; i < 8; i++) vals[i] = 16'($urandom) ^ 16'(i << 12);
    for (int i = 0; i < 8; i++) begin
      idle2(); d2.Bus2_Sel = 2'd2; d2.Rd_Load = 1; d2.Rd_Sel = 3'(i); d2.from_memory = vals[i];
      step2(16'h0BCD, 12'hBCD);
    end
    for (int i = 0; i < 8; i++) begin
      idle2(); d2.Bus1_Sel = 2'd1; d2.Rs_Sel = 3'(i);
      step2(vals[i], 12'hBCD);
    end
    idle2();

    @(negedge clk);
    #1;
    cmp("scoreboard_drained", 32'(exp_q.size() + exp2_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
